// File: rtl/lib_switch_pkg.sv
// Shared types and helpers for the round-robin switch allocator.
// Selects the optional grant-lock feature with macro LIB_SWITCH_ALLOC_LOCK_EN.
package lib_switch_pkg;

    // Per-output select vector; element j corresponds to input j.
    typedef logic [0:31] sel_t;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if ((32'd1 << k) < n) w = k + 1;
        end
        return w;
    endfunction

    // One-hot of the first set bit of vec, searching ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
    function automatic sel_t first_set_rr(input sel_t vec, input int unsigned ptr,
                                          input int unsigned n);
        sel_t        res;
        logic        found;
        int unsigned idx;
        res   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 32; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if ((k < n) && !found && vec[idx[4:0]]) begin
                res[idx[4:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lib_switch_alloc_rr_arbiter.sv
// Single-output round-robin arbiter with registered one-hot grant and grant lock.
// Lock input is only ever driven when LIB_SWITCH_ALLOC_LOCK_EN is defined at the top.
module lib_arbiter_rr_1ofn
    import lib_switch_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ce,
    input  logic [0:N-1] i_req,
    input  logic         i_lock,
    output logic [0:N-1] o_gnt
);

    localparam int PW = (clog2(N) < 1) ? 1 : clog2(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [0:N-1]  gnt_q, gnt_d;
    arb_state_e    state_q, state_d;
    sel_t          req_w;
    sel_t          win_w;

    always_comb begin
        req_w = '0;
        for (int j = 0; j < N; j++) req_w[j] = i_req[j];
        win_w = first_set_rr(req_w, {{(32-PW){1'b0}}, ptr_q}, N);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        if (ce) begin
            case (state_q)
                ARB_OPEN:   if (i_lock && (|gnt_q)) state_d = ARB_LOCKED;
                ARB_LOCKED: if (!i_lock) state_d = ARB_OPEN;
                default:    state_d = ARB_OPEN;
            endcase
            // While locked the current grant repeats and the pointer stays put.
            if (state_d != ARB_LOCKED) begin
                gnt_d = '0;
                for (int j = 0; j < N; j++) begin
                    gnt_d[j] = win_w[j];
                    if (win_w[j]) ptr_d = (j == N - 1) ? '0 : PW'(j + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_OPEN;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_gnt = gnt_q;

endmodule

// File: rtl/lib_switch_alloc_rr.sv
// NxM round-robin output-port allocator driving a one-hot crossbar select.
// Define LIB_SWITCH_ALLOC_LOCK_EN to add i_hold and multi-cycle grant locking.
module lib_switch_alloc_rr
    import lib_switch_pkg::*;
#(
    parameter int N = 5,
    parameter int M = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic [0:N-1][0:M-1]  i_req,
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
    input  logic [0:N-1]         i_hold,
`endif
    output logic [0:M-1][0:N-1]  o_sel,
    output logic [0:N-1]         o_gnt
);

    logic [0:N-1][0:M-1] req_s;
    logic [0:M-1][0:N-1] col_w;
    logic [0:M-1]        lock_w;

    // Keep only the lowest requested output per input row.
    always_comb begin : sanitise
        logic found;
        req_s = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            found = 1'b0;
            for (int i = 0; i < M; i++) begin
                if (i_req[j][i] && !found) begin
                    req_s[j][i] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

    always_comb begin
        col_w = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) col_w[i][j] = req_s[j][i];
        end
    end

`ifdef LIB_SWITCH_ALLOC_LOCK_EN
    always_comb begin
        lock_w = '0;
        for (int i = 0; i < M; i++) lock_w[i] = |(o_sel[i] & i_hold);
    end
`else
    assign lock_w = '0;
`endif

    for (genvar g = 0; g < M; g++) begin : g_arb
        lib_arbiter_rr_1ofn #(.N(N)) u_arb (
            .clk     (clk),
            .reset_n (reset_n),
            .ce      (ce),
            .i_req   (col_w[g]),
            .i_lock  (lock_w[g]),
            .o_gnt   (o_sel[g])
        );
    end

    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < M; i++) o_gnt = o_gnt | o_sel[i];
    end

endmodule

// File: tb/tb_lib_switch_alloc_rr.sv
// Directed self-checking bench for lib_switch_alloc_rr (N=5, M=5).
// Lock scenario is compiled only when LIB_SWITCH_ALLOC_LOCK_EN is defined.
module tb_lib_switch_alloc_rr;

    localparam int N = 5;
    localparam int M = 5;

    logic                clk;
    logic                reset_n;
    logic                ce;
    logic [0:N-1][0:M-1] i_req;
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
    logic [0:N-1]        i_hold;
`endif
    logic [0:M-1][0:N-1] o_sel;
    logic [0:N-1]        o_gnt;

    int n_checks;
    int n_errors;

    lib_switch_alloc_rr #(.N(N), .M(M)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .i_req   (i_req),
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
        .i_hold  (i_hold),
`endif
        .o_sel   (o_sel),
        .o_gnt   (o_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b", tag, got[N-1:0], exp[N-1:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_req   = '0;
        ce      = 1'b1;
        step();
        reset_n = 1'b1;
    endtask

    task automatic all_req(input int out);
        i_req = '0;
        for (int j = 0; j < N; j++) i_req[j][out] = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        ce       = 1'b1;
        i_req    = '0;
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
        i_hold   = '0;
`endif
        #1;
        chk("reset_sel0", o_sel[0], 5'b00000);
        chk("reset_gnt", o_gnt, 5'b00000);

        // Mid-cycle asynchronous reset drops grants immediately.
        do_reset();
        all_req(0);
        step();
        chk("t1_sel0_a", o_sel[0], 5'b10000);
        step();
        chk("t1_sel0_b", o_sel[0], 5'b01000);
        #2 reset_n = 1'b0;
        #1;
        chk("t1_async_sel0", o_sel[0], 5'b00000);
        chk("t1_async_gnt", o_gnt, 5'b00000);
        step();
        reset_n = 1'b1;
        step();
        chk("t1_after_rst", o_sel[0], 5'b10000);
        chk("t1_after_gnt", o_gnt, 5'b10000);

        // Fairness on output 2 with wrap 4 -> 0.
        do_reset();
        all_req(2);
        step(); chk("t2_g0", o_sel[2], 5'b10000);
        step(); chk("t2_g1", o_sel[2], 5'b01000);
        step(); chk("t2_g2", o_sel[2], 5'b00100);
        step(); chk("t2_g3", o_sel[2], 5'b00010);
        step(); chk("t2_g4", o_sel[2], 5'b00001);
        step(); chk("t2_wrap", o_sel[2], 5'b10000);

        // Independent outputs arbitrate in parallel.
        do_reset();
        i_req    = '0;
        i_req[0] = 5'b01000;
        i_req[1] = 5'b00010;
        i_req[4] = 5'b01000;
        step();
        chk("t3_sel1_a", o_sel[1], 5'b10000);
        chk("t3_sel3_a", o_sel[3], 5'b01000);
        chk("t3_gnt_a", o_gnt, 5'b11000);
        step();
        chk("t3_sel1_b", o_sel[1], 5'b00001);
        chk("t3_sel3_b", o_sel[3], 5'b01000);
        chk("t3_gnt_b", o_gnt, 5'b01001);

        // Clock enable freezes outputs and pointers.
        do_reset();
        i_req    = '0;
        i_req[2] = 5'b10000;
        step();
        chk("t4_grant", o_sel[0], 5'b00100);
        ce = 1'b0;
        all_req(0);
        step();
        chk("t4_hold1", o_sel[0], 5'b00100);
        i_req = '0;
        i_req[1] = 5'b00010;
        step();
        chk("t4_hold2_sel3", o_sel[3], 5'b00000);
        all_req(0);
        step();
        chk("t4_hold3", o_sel[0], 5'b00100);
        chk("t4_hold_gnt", o_gnt, 5'b00100);
        ce = 1'b1;
        step();
        chk("t4_resume", o_sel[0], 5'b00010);
        step();
        chk("t4_next", o_sel[0], 5'b00001);

        // Multi-bit request row counts only for its lowest output.
        do_reset();
        i_req    = '0;
        i_req[3] = 5'b01100;
        step();
        chk("t5_sel1", o_sel[1], 5'b00010);
        chk("t5_sel2", o_sel[2], 5'b00000);
        chk("t5_gnt", o_gnt, 5'b00010);

`ifdef LIB_SWITCH_ALLOC_LOCK_EN
        // Held grant persists while another input waits.
        do_reset();
        i_req     = '0;
        i_req[1]  = 5'b00001;
        i_req[2]  = 5'b00001;
        i_hold    = '0;
        i_hold[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("t6_lock%0d", c), o_sel[4], 5'b01000);
        end
        i_hold = '0;
        step();
        chk("t6_release", o_sel[4], 5'b00100);
        step();
        chk("t6_ptr3", o_sel[4], 5'b01000);
        i_req = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
